// File: rtl/unary_add_n.sv
// ---------------------------------------------------------------------------
// unary_add_n
//
// N-input unary (stream-count) adder. The read phase counts the 1s seen on
// NUM_IN serial unary lanes. The write phase replays that total as a unary
// stream: dout is high for exactly `count` enabled cycles, then done rises.
// Overflow either clamps or wraps, depending on SAT_MODE. The sticky C flag
// records that the current frame went past the counter's range.
//
// Parameters
//   NUM_IN   - number of serial unary input lanes (1..16)
//   CNT_W    - accumulator / emit-counter width (max count 2**CNT_W-1)
//   SAT_MODE - 1 = clamp at max on overflow, 0 = wrap modulo 2**CNT_W
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   en            in   clock enable; 0 freezes every register
//   clr           in   synchronous clear (qualified by en)
//   read_or_write in   0 = accumulate, 1 = emit
//   din           in   one unary bit per lane
//   dout          out  registered unary output stream
//   C             out  sticky overflow/carry flag
//   done          out  emission complete
//   count         out  current accumulated value
// ---------------------------------------------------------------------------
module unary_add_n #(
    parameter int NUM_IN   = 2,
    parameter int CNT_W    = 4,
    parameter bit SAT_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              read_or_write,
    input  logic [NUM_IN-1:0] din,
    output logic              dout,
    output logic              C,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    // The popcount is wide enough for all lanes high at once. The sum is
    // wide enough to hold count + popcount without losing the carry.
    localparam int POP_W = $clog2(NUM_IN + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;
    logic               dout_q,  dout_d;
    logic               c_q,     c_d;
    logic               done_q,  done_d;

    logic [POP_W-1:0]   pop;
    logic [SUM_W-1:0]   acc_sum;
    logic               acc_ovf;
    logic [CNT_W-1:0]   acc_val;
    logic [SUM_W-1:0]   fresh_sum;
    logic               fresh_ovf;
    logic [CNT_W-1:0]   fresh_val;

    // Count the lanes that are high on this edge. All lanes land in the
    // same cycle, so the order of the lanes does not matter.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            pop = pop + POP_W'(din[i]);
        end
    end

    // The candidate accumulator value has two sources. acc_* continues the
    // running frame. fresh_* starts a new frame from zero, which happens
    // when DONE sees rw=0. Both paths apply the same overflow policy.
    always_comb begin
        acc_sum   = SUM_W'(count_q) + SUM_W'(pop);
        acc_ovf   = (acc_sum > SUM_W'(CNT_MAX));
        acc_val   = acc_ovf ? (SAT_MODE ? CNT_MAX : acc_sum[CNT_W-1:0])
                            : acc_sum[CNT_W-1:0];
        fresh_sum = SUM_W'(pop);
        fresh_ovf = (fresh_sum > SUM_W'(CNT_MAX));
        fresh_val = fresh_ovf ? (SAT_MODE ? CNT_MAX : fresh_sum[CNT_W-1:0])
                              : fresh_sum[CNT_W-1:0];
    end

    // Next-state and next-output logic. Every register defaults to holding
    // its value. clr takes priority over read_or_write, which takes
    // priority over din. Emission counts down a separate rem copy, so count
    // stays readable while the stream is replayed.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        c_d     = c_q;
        done_d  = done_q;

        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            rem_d   = '0;
            dout_d  = 1'b0;
            c_d     = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    dout_d = 1'b0;
                    if (read_or_write) begin
                        // Entry edge: latch the total and start emitting
                        // on the next edge.
                        rem_d   = count_q;
                        state_d = EMIT;
                    end else begin
                        state_d = ACCUM;
                        count_d = acc_val;
                        if (acc_ovf) begin
                            c_d = 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (read_or_write) begin
                        if (rem_q != '0) begin
                            dout_d = 1'b1;
                            rem_d  = rem_q - CNT_W'(1);
                        end else begin
                            dout_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        // Abort: stop the stream and keep the running total.
                        // This edge's data still counts.
                        dout_d  = 1'b0;
                        rem_d   = '0;
                        state_d = ACCUM;
                        count_d = acc_val;
                        if (acc_ovf) begin
                            c_d = 1'b1;
                        end
                    end
                end

                DONE: begin
                    dout_d = 1'b0;
                    if (read_or_write) begin
                        done_d = 1'b1;
                    end else begin
                        // A new frame starts with this edge's data.
                        state_d = ACCUM;
                        count_d = fresh_val;
                        c_d     = fresh_ovf;
                        done_d  = 1'b0;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers. Reset clears them asynchronously. With
    // en low every register holds, so a frozen emission resumes without
    // losing or adding high cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dout_q  <= 1'b0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    assign dout  = dout_q;
    assign C     = c_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_unary_add_n.sv
// ---------------------------------------------------------------------------
// tb_unary_add_n
//
// Directed bench for unary_add_n. Three instances share clock, reset and
// control signals:
//   dut_a - NUM_IN=2, CNT_W=4, saturating
//   dut_b - NUM_IN=2, CNT_W=4, wrapping
//   dut_c - NUM_IN=4, CNT_W=4, saturating
// Inputs change 1 time unit after each rising edge. Outputs are sampled at
// that same point.
// ---------------------------------------------------------------------------
module tb_unary_add_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       rw;
    logic [1:0] din2;
    logic [3:0] din4;

    logic       a_dout, a_c, a_done;
    logic [3:0] a_count;
    logic       b_dout, b_c, b_done;
    logic [3:0] b_count;
    logic       c_dout, c_c, c_done;
    logic [3:0] c_count;

    int n_compared;
    int n_mismatched;

    unary_add_n #(.NUM_IN(2), .CNT_W(4), .SAT_MODE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .read_or_write(rw),
        .din(din2), .dout(a_dout), .C(a_c), .done(a_done), .count(a_count)
    );

    unary_add_n #(.NUM_IN(2), .CNT_W(4), .SAT_MODE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .read_or_write(rw),
        .din(din2), .dout(b_dout), .C(b_c), .done(b_done), .count(b_count)
    );

    unary_add_n #(.NUM_IN(4), .CNT_W(4), .SAT_MODE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .read_or_write(rw),
        .din(din4), .dout(c_dout), .C(c_c), .done(c_done), .count(c_count)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the data-path inputs, then take one edge.
    task automatic apply_stimulus(input logic rw_v, input logic [1:0] d2,
                                  input logic [3:0] d4);
        rw   = rw_v;
        din2 = d2;
        din4 = d4;
        tick();
    endtask

    // One comparison: count it, and report it if it mismatches.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        rw   = 1'b0;
        din2 = 2'b00;
        din4 = 4'b0000;
        #12;

        // Reset state
        check_output("reset_count", 32'(a_count), 0);
        check_output("reset_dout",  32'(a_dout),  0);
        check_output("reset_c",     32'(a_c),     0);
        check_output("reset_done",  32'(a_done),  0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        #1;

        // din=11 for 10 cycles: raw sum 20, so saturate to 15 or wrap to 4
        for (int i = 1; i <= 10; i++) begin
            apply_stimulus(1'b0, 2'b11, 4'b0000);
            if (i == 7) begin
                check_output("sat_cnt_14",  32'(a_count), 14);
                check_output("sat_c_14",    32'(a_c),     0);
            end
            if (i == 8) begin
                check_output("sat_cnt_16",  32'(a_count), 15);
                check_output("sat_c_16",    32'(a_c),     1);
                check_output("wrap_cnt_16", 32'(b_count), 0);
                check_output("wrap_c_16",   32'(b_c),     1);
            end
        end
        check_output("sat_count",  32'(a_count), 15);
        check_output("sat_c",      32'(a_c),     1);
        check_output("wrap_count", 32'(b_count), 4);
        check_output("wrap_c",     32'(b_c),     1);

        // Entry edge, then 15 highs (sat) and 4 highs (wrap)
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        check_output("entry_dout_a", 32'(a_dout), 0);
        check_output("entry_dout_b", 32'(b_dout), 0);
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(1'b1, 2'b11, 4'b0000);
            check_output($sformatf("sat_dout_%0d", i),  32'(a_dout), (i <= 15) ? 1 : 0);
            check_output($sformatf("sat_done_%0d", i),  32'(a_done), (i >= 16) ? 1 : 0);
            check_output($sformatf("wrap_dout_%0d", i), 32'(b_dout), (i <= 4)  ? 1 : 0);
            check_output($sformatf("wrap_done_%0d", i), 32'(b_done), (i >= 5)  ? 1 : 0);
        end
        check_output("emit_keeps_count", 32'(a_count), 15);

        // Synchronous clear
        clr = 1'b1;
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        clr = 1'b0;
        check_output("clr_count", 32'(a_count), 0);
        check_output("clr_c",     32'(a_c),     0);
        check_output("clr_done",  32'(a_done),  0);

        // count=0 emission: no pulse, and done one edge after entry
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        check_output("zero_entry_dout", 32'(a_dout), 0);
        check_output("zero_entry_done", 32'(a_done), 0);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        check_output("zero_dout", 32'(a_dout), 0);
        check_output("zero_done", 32'(a_done), 1);

        // Four lanes: 0101 + 1111 + 0000 = 6
        clr = 1'b1;
        apply_stimulus(1'b0, 2'b00, 4'b0000);
        clr = 1'b0;
        apply_stimulus(1'b0, 2'b00, 4'b0101);
        check_output("n4_count_2", 32'(c_count), 2);
        apply_stimulus(1'b0, 2'b00, 4'b1111);
        apply_stimulus(1'b0, 2'b00, 4'b0000);
        check_output("n4_count", 32'(c_count), 6);
        check_output("n4_c",     32'(c_c),     0);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus(1'b1, 2'b00, 4'b0000);
            check_output($sformatf("n4_dout_%0d", i), 32'(c_dout), (i <= 6) ? 1 : 0);
        end
        check_output("n4_done", 32'(c_done), 1);

        // Clock-enable freeze mid-emission: count=5
        clr = 1'b1;
        apply_stimulus(1'b0, 2'b00, 4'b0000);
        clr = 1'b0;
        apply_stimulus(1'b0, 2'b11, 4'b0000);
        apply_stimulus(1'b0, 2'b11, 4'b0000);
        apply_stimulus(1'b0, 2'b01, 4'b0000);
        check_output("frz_count", 32'(a_count), 5);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        check_output("frz_pre_dout", 32'(a_dout), 1);
        en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(1'b1, 2'b11, 4'b0000);
            check_output($sformatf("frz_hold_dout_%0d", i), 32'(a_dout), 1);
            check_output($sformatf("frz_hold_cnt_%0d", i),  32'(a_count), 5);
        end
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, 2'b00, 4'b0000);
            check_output($sformatf("frz_dout_%0d", i), 32'(a_dout), (i <= 3) ? 1 : 0);
        end
        check_output("frz_done", 32'(a_done), 1);

        // Abort mid-emission with din=01: 5 + 1 = 6
        clr = 1'b1;
        apply_stimulus(1'b0, 2'b00, 4'b0000);
        clr = 1'b0;
        apply_stimulus(1'b0, 2'b11, 4'b0000);
        apply_stimulus(1'b0, 2'b11, 4'b0000);
        apply_stimulus(1'b0, 2'b01, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b0, 2'b01, 4'b0000);
        check_output("abort_dout",  32'(a_dout),  0);
        check_output("abort_count", 32'(a_count), 6);
        check_output("abort_done",  32'(a_done),  0);
        apply_stimulus(1'b0, 2'b00, 4'b0000);
        check_output("abort_accum_hold", 32'(a_count), 6);

        // Push to overflow, then assert an asynchronous reset mid-emission
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b0, 2'b11, 4'b0000);
        end
        check_output("pre_rst_count", 32'(a_count), 15);
        check_output("pre_rst_c",     32'(a_c),     1);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        check_output("pre_rst_dout", 32'(a_dout), 1);
        #1;
        rst = 1'b1;
        #1;
        check_output("arst_dout",  32'(a_dout),  0);
        check_output("arst_c",     32'(a_c),     0);
        check_output("arst_done",  32'(a_done),  0);
        check_output("arst_count", 32'(a_count), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // clr while in DONE, then an empty frame from IDLE
        apply_stimulus(1'b0, 2'b11, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        check_output("pre_clr_done",  32'(a_done),  1);
        check_output("pre_clr_count", 32'(a_count), 2);
        clr = 1'b1;
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        clr = 1'b0;
        check_output("done_clr_count", 32'(a_count), 0);
        check_output("done_clr_done",  32'(a_done),  0);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        apply_stimulus(1'b1, 2'b00, 4'b0000);
        check_output("idle_empty_done", 32'(a_done), 1);

        // DONE with rw=0 starts a new frame with this edge's data
        apply_stimulus(1'b0, 2'b01, 4'b0000);
        check_output("new_frame_count", 32'(a_count), 1);
        check_output("new_frame_done",  32'(a_done),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/unary_add_n.md
Name: unary_add_n

Overview:
- Parametrised N-input unary (stream-count) adder, the next generation of the fixed two-input unary adder.
- Read phase: accumulates the number of 1s seen on NUM_IN serial unary inputs.
- Write phase: replays the sum as a unary stream, i.e. dout is high for exactly `count` cycles.
- Adds selectable saturate/wrap overflow, sticky carry flag, done status, abort and synchronous clear; sits between unary stream sources and downstream unary consumers.

Parameters:
- NUM_IN, 2, number of serial unary input lanes (1..16).
- CNT_W, 4, accumulator and emit-counter width; max count is 2**CNT_W-1.
- SAT_MODE, 1, overflow policy: 1 = clamp count at max, 0 = wrap modulo 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  clock enable; 0 freezes all state and outputs.
- clr  input  1  synchronous clear; acts only when en=1.
- read_or_write  input  1  0 = accumulate (read), 1 = emit (write).
- din  input  NUM_IN  one unary bit per lane, sampled each enabled edge.
- dout  output  1  registered unary output stream.
- C  output  1  sticky overflow/carry flag.
- done  output  1  high once emission is complete.
- count  output  CNT_W  current accumulated value.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; count=0, rem=0, dout=0, C=0, done=0.
- States: IDLE, ACCUM, EMIT, DONE. All transitions occur on enabled edges only (en=1).
- Priority per enabled edge: clr > read_or_write > din.
- clr=1, any state: count=0, rem=0, C=0, done=0, dout=0; state becomes IDLE.
- IDLE or ACCUM with rw=0:
  - state becomes ACCUM.
  - sum = count + popcount(din), computed at width CNT_W+clog2(NUM_IN+1).
  - If sum > 2**CNT_W-1: C<=1 (sticky). count becomes 2**CNT_W-1 when SAT_MODE=1, or sum mod 2**CNT_W when SAT_MODE=0.
  - Otherwise count<=sum.
  - dout stays 0.
- IDLE or ACCUM with rw=1 (entry edge): rem<=count; state becomes EMIT; dout stays 0 on this edge; din is ignored.
- EMIT with rw=1:
  - If rem!=0: dout<=1, rem<=rem-1.
  - If rem==0: dout<=0, done<=1, state becomes DONE.
  - Result: dout is high for exactly `count` consecutive enabled cycles, starting at the first enabled edge after the entry edge.
  - count=0 gives no high pulse; done rises on the first edge after entry.
- EMIT with rw=0 (abort): dout<=0, rem<=0; state becomes ACCUM. count and C are retained, and that edge's din is accumulated.
- DONE with rw=1: hold; dout=0, done=1.
- DONE with rw=0: count<=popcount(din) (a new frame starts with this edge's data); C and done cleared; state becomes ACCUM.
- en=0: every register holds its value, including dout mid-emission. Emission resumes when en returns to 1, so the total number of high cycles is unchanged.
- count remains readable during EMIT and DONE; emission does not consume it, since it uses the separate rem counter.
- rst asserted mid-emission: all outputs go to 0 immediately, without waiting for a clock edge.
- Multiple lanes high on the same edge add together in one cycle; there is no per-lane ordering.

Test Plan:
- NUM_IN=2, CNT_W=4, SAT_MODE=1. Apply din=2'b11 for 10 enabled cycles, then rw=1. Required: count=15 and C=1 (raw sum 20); after entry edge, dout high for 15 cycles, then done=1, dout=0.
- Same stimulus with SAT_MODE=0. Required: count=4, C=1; dout high for 4 cycles, then done=1.
- NUM_IN=4. Apply din=4'b0101, 4'b1111, 4'b0000. Required: count=6, C=0; dout high for exactly 6 cycles.
- count=0, then rw=1. Required: dout never rises; done=1 one enabled edge after entry.
- count=5; drop en for 3 cycles after 2 dout highs. Required: dout frozen at 1, then 3 more highs; 5 highs total.
- Mid-EMIT, set rw=0 with din=2'b01. Required: dout=0 and state ACCUM with count=6. Separately: rst pulse mid-EMIT, required: dout=C=done=count=0 asynchronously. Separately: clr=1 while in DONE, required: count=0, state IDLE.
